// File: rtl/countdown_ctrl.sv
// Countdown timer control FSM: MM:SS BCD value, preset keys, start/pause/stop, alarm at 00:00.
// Latency: 1 CLK cycle from a strobe sampled with CE=1 to the registered outputs.
// Backpressure: none; strobes sampled with CE=0 are dropped, never queued.
module countdown_ctrl #(
  parameter int MAX_MIN     = 99,
  parameter int ALARM_TICKS = 10
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        CE,
  input  logic        TICK,
  input  logic        KEY_START,
  input  logic        KEY_STOP,
  input  logic        KEY_INC,
  input  logic        KEY_DEC,
  output logic [15:0] Q,
  output logic        RUN,
  output logic        ALARM,
  output logic        BLANK
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Minutes ceiling as two BCD digits; BCD compares like binary when digits are valid.
  localparam logic [7:0] MAX_MIN_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
  localparam logic [7:0] ALARM_LIM   = 8'(ALARM_TICKS);

  state_t      state_r;
  state_t      state_nxt;
  logic [15:0] q_r;
  logic [15:0] q_nxt;
  logic [15:0] preset_r;
  logic [15:0] preset_nxt;
  logic [7:0]  cnt_r;
  logic [7:0]  cnt_nxt;
  logic        blank_r;
  logic        blank_nxt;

  logic        key_stop;
  logic        key_start;
  logic        key_inc;
  logic        key_dec;
  logic        any_key;
  logic [15:0] q_inc;
  logic [15:0] q_dec;
  logic [7:0]  cnt_inc;
  logic        alarm_expire;

  // +1 s on the BCD value, saturating at MAX_MIN:59.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[15:8] >= MAX_MIN_BCD && v[7:0] == 8'h59) begin
      r = v;
    end else if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd5) begin
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (v[11:8] != 4'd9) begin
          r[11:8] = v[11:8] + 4'd1;
        end else begin
          r[11:8]  = 4'd0;
          r[15:12] = v[15:12] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  // -1 s on the BCD value, saturating at 00:00.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v == 16'h0000) begin
      r = v;
    end else if (v[3:0] != 4'd0) begin
      r[3:0] = v[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) begin
        r[7:4] = v[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (v[11:8] != 4'd0) begin
          r[11:8] = v[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = v[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  // Key priority decode: STOP > START > INC > DEC, only one key acts per cycle.
  always_comb begin
    key_stop     = KEY_STOP;
    key_start    = KEY_START & ~KEY_STOP;
    key_inc      = KEY_INC & ~KEY_START & ~KEY_STOP;
    key_dec      = KEY_DEC & ~KEY_INC & ~KEY_START & ~KEY_STOP;
    any_key      = KEY_STOP | KEY_START | KEY_INC | KEY_DEC;
    q_inc        = bcd_inc(q_r);
    q_dec        = bcd_dec(q_r);
    cnt_inc      = cnt_r + 8'd1;
    alarm_expire = TICK && (cnt_inc == ALARM_LIM);
  end

  // State register; CLR wins over CE.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_r <= ST_IDLE;
    end else if (CE) begin
      state_r <= state_nxt;
    end
  end

  // Datapath registers: time value, preset, alarm counter and blink phase.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      q_r      <= 16'h0000;
      preset_r <= 16'h0000;
      cnt_r    <= 8'd0;
      blank_r  <= 1'b0;
    end else if (CE) begin
      q_r      <= q_nxt;
      preset_r <= preset_nxt;
      cnt_r    <= cnt_nxt;
      blank_r  <= blank_nxt;
    end
  end

  // Next-state logic. In RUN, INC/DEC are ignored and do not block a TICK.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (key_start && q_r != 16'h0000) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (key_stop)                            state_nxt = ST_IDLE;
        else if (key_start)                      state_nxt = ST_PAUSE;
        else if (TICK && q_dec == 16'h0000)      state_nxt = ST_DONE;
      end
      ST_PAUSE: begin
        if (key_stop)       state_nxt = ST_IDLE;
        else if (key_start) state_nxt = ST_RUN;
      end
      ST_DONE: begin
        if (any_key || alarm_expire) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output/datapath logic: next value of Q, preset, alarm counter and BLANK.
  always_comb begin
    q_nxt      = q_r;
    preset_nxt = preset_r;
    cnt_nxt    = cnt_r;
    blank_nxt  = blank_r;
    case (state_r)
      ST_IDLE: begin
        blank_nxt = 1'b0;
        if (key_stop) begin
          q_nxt = 16'h0000;
        end else if (key_start) begin
          if (q_r != 16'h0000) preset_nxt = q_r;
        end else if (key_inc) begin
          q_nxt = q_inc;
        end else if (key_dec) begin
          q_nxt = q_dec;
        end
      end
      ST_RUN: begin
        if (key_stop) begin
          q_nxt = preset_r;
        end else if (key_start) begin
          q_nxt = q_r;
        end else if (TICK) begin
          q_nxt = q_dec;
          if (q_dec == 16'h0000) begin
            cnt_nxt   = 8'd0;
            blank_nxt = 1'b0;
          end
        end
      end
      ST_PAUSE: begin
        if (key_stop) q_nxt = preset_r;
      end
      ST_DONE: begin
        // A key only dismisses the alarm; its own function is not applied.
        if (any_key || alarm_expire) begin
          q_nxt     = preset_r;
          cnt_nxt   = 8'd0;
          blank_nxt = 1'b0;
        end else if (TICK) begin
          cnt_nxt   = cnt_inc;
          blank_nxt = ~blank_r;
        end
      end
      default: begin
        blank_nxt = 1'b0;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  assign Q     = q_r;
  assign RUN   = (state_r == ST_RUN);
  assign ALARM = (state_r == ST_DONE);
  assign BLANK = blank_r;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Self-checking bench for countdown_ctrl: directed plan plus random traffic against a seconds-based model.
// Latency: model and DUT both update at the CLK edge where inputs are sampled.
// Backpressure: none; CE is randomised to exercise dropped strobes.
module tb_countdown_ctrl;

  localparam int MAX_MIN     = 99;
  localparam int ALARM_TICKS = 10;
  localparam int MAX_SEC     = MAX_MIN * 60 + 59;

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic        CE = 1'b1;
  logic        TICK = 1'b0;
  logic        KEY_START = 1'b0;
  logic        KEY_STOP = 1'b0;
  logic        KEY_INC = 1'b0;
  logic        KEY_DEC = 1'b0;
  logic [15:0] Q;
  logic        RUN;
  logic        ALARM;
  logic        BLANK;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Model state: time as plain seconds, mode as a small integer.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_sec   = 0;
  int m_pre   = 0;
  int m_cnt   = 0;
  int m_mode  = M_IDLE;
  bit m_blank = 1'b0;

  countdown_ctrl #(.MAX_MIN(MAX_MIN), .ALARM_TICKS(ALARM_TICKS)) dut (
    .CLK(CLK), .CLR(CLR), .CE(CE), .TICK(TICK),
    .KEY_START(KEY_START), .KEY_STOP(KEY_STOP), .KEY_INC(KEY_INC), .KEY_DEC(KEY_DEC),
    .Q(Q), .RUN(RUN), .ALARM(ALARM), .BLANK(BLANK)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] to_bcd(input int s);
    int m;
    int ss;
    m  = s / 60;
    ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  // Reference behaviour from the timer rules, in whole seconds.
  always @(posedge CLK) begin
    if (CLR) begin
      m_mode = M_IDLE; m_sec = 0; m_pre = 0; m_cnt = 0; m_blank = 1'b0;
    end else if (CE) begin
      case (m_mode)
        M_IDLE: begin
          if (KEY_STOP) m_sec = 0;
          else if (KEY_START) begin
            if (m_sec != 0) begin m_pre = m_sec; m_mode = M_RUN; end
          end
          else if (KEY_INC) begin if (m_sec < MAX_SEC) m_sec++; end
          else if (KEY_DEC) begin if (m_sec > 0) m_sec--; end
        end
        M_RUN: begin
          if (KEY_STOP) begin m_sec = m_pre; m_mode = M_IDLE; end
          else if (KEY_START) m_mode = M_PAUSE;
          else if (TICK) begin
            if (m_sec > 0) m_sec--;
            if (m_sec == 0) begin m_mode = M_DONE; m_cnt = 0; m_blank = 1'b0; end
          end
        end
        M_PAUSE: begin
          if (KEY_STOP) begin m_sec = m_pre; m_mode = M_IDLE; end
          else if (KEY_START) m_mode = M_RUN;
        end
        default: begin
          if (KEY_STOP || KEY_START || KEY_INC || KEY_DEC) begin
            m_mode = M_IDLE; m_sec = m_pre; m_blank = 1'b0; m_cnt = 0;
          end else if (TICK) begin
            m_cnt++;
            if (m_cnt == ALARM_TICKS) begin
              m_mode = M_IDLE; m_sec = m_pre; m_blank = 1'b0; m_cnt = 0;
            end else begin
              m_blank = ~m_blank;
            end
          end
        end
      endcase
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      checks++;
      if (Q !== to_bcd(m_sec) || RUN !== (m_mode == M_RUN) ||
          ALARM !== (m_mode == M_DONE) || BLANK !== m_blank) begin
        failures++;
        $display("FAIL model_cmp t=%0t got Q=%h RUN=%b ALARM=%b BLANK=%b want Q=%h RUN=%b ALARM=%b BLANK=%b",
                 $time, Q, RUN, ALARM, BLANK, to_bcd(m_sec), m_mode == M_RUN, m_mode == M_DONE, m_blank);
      end
    end
  end

  // One clock cycle with the given inputs; k = {STOP, START, INC, DEC}.
  task automatic cyc(input bit ce, input bit clr, input bit tick, input bit [3:0] k);
    CE = ce; CLR = clr; TICK = tick;
    KEY_STOP = k[3]; KEY_START = k[2]; KEY_INC = k[1]; KEY_DEC = k[0];
    @(posedge CLK);
    #1;
    CE = 1'b1; CLR = 1'b0; TICK = 1'b0;
    KEY_STOP = 1'b0; KEY_START = 1'b0; KEY_INC = 1'b0; KEY_DEC = 1'b0;
  endtask

  // Literal expectation, hand-computed from the timer rules.
  task automatic chk(input string nm, input logic [15:0] q_e, input bit run_e, input bit alm_e, input bit blk_e);
    checks++;
    if (Q !== q_e || RUN !== run_e || ALARM !== alm_e || BLANK !== blk_e) begin
      failures++;
      $display("FAIL %s got Q=%h RUN=%b ALARM=%b BLANK=%b want Q=%h RUN=%b ALARM=%b BLANK=%b",
               nm, Q, RUN, ALARM, BLANK, q_e, run_e, alm_e, blk_e);
    end
  endtask

  localparam bit [3:0] K_NONE = 4'b0000, K_STOP = 4'b1000, K_START = 4'b0100,
                       K_INC = 4'b0010, K_DEC = 4'b0001;

  initial begin
    cyc(1, 1, 0, K_NONE);
    chk_en = 1'b1;
    chk("reset", 16'h0000, 0, 0, 0);

    // 3 x INC, START, count down to alarm.
    cyc(1, 0, 0, K_INC); chk("inc1", 16'h0001, 0, 0, 0);
    cyc(1, 0, 0, K_INC); chk("inc2", 16'h0002, 0, 0, 0);
    cyc(1, 0, 0, K_INC); chk("inc3", 16'h0003, 0, 0, 0);
    cyc(1, 0, 0, K_START); chk("start", 16'h0003, 1, 0, 0);
    cyc(1, 0, 1, K_NONE); chk("tick1", 16'h0002, 1, 0, 0);
    cyc(1, 0, 1, K_NONE); chk("tick2", 16'h0001, 1, 0, 0);
    cyc(1, 0, 1, K_NONE); chk("tick_done", 16'h0000, 0, 1, 0);

    // Alarm blink then auto-return with the preset restored.
    for (int i = 1; i <= ALARM_TICKS - 1; i++) begin
      cyc(1, 0, 1, K_NONE);
      chk("alarm_blink", 16'h0000, 0, 1, bit'(i % 2));
    end
    cyc(1, 0, 1, K_NONE); chk("alarm_expire", 16'h0003, 0, 0, 0);

    // Dismiss the alarm with INC: preset restored, INC not applied.
    cyc(1, 0, 0, K_START);
    repeat (3) cyc(1, 0, 1, K_NONE);
    chk("done_again", 16'h0000, 0, 1, 0);
    repeat (2) cyc(1, 0, 1, K_NONE);
    cyc(1, 0, 0, K_INC); chk("dismiss_inc", 16'h0003, 0, 0, 0);

    // DEC and START at zero do nothing.
    cyc(1, 0, 0, K_STOP); chk("stop_idle", 16'h0000, 0, 0, 0);
    cyc(1, 0, 0, K_DEC); chk("dec_zero", 16'h0000, 0, 0, 0);
    cyc(1, 0, 0, K_START); chk("start_zero", 16'h0000, 0, 0, 0);

    // Borrow across S1 and M0.
    repeat (60) cyc(1, 0, 0, K_INC);
    chk("set_0100", 16'h0100, 0, 0, 0);
    cyc(1, 0, 0, K_START);
    cyc(1, 0, 1, K_NONE); chk("borrow", 16'h0059, 1, 0, 0);
    cyc(1, 0, 1, K_NONE); chk("tick_0058", 16'h0058, 1, 0, 0);
    cyc(1, 0, 0, K_STOP); chk("stop_preset", 16'h0100, 0, 0, 0);

    // Pause with a coincident TICK, resume, stop.
    repeat (30) cyc(1, 0, 0, K_INC);
    cyc(1, 0, 0, K_START); chk("run_0130", 16'h0130, 1, 0, 0);
    cyc(1, 0, 1, K_START); chk("pause_drop_tick", 16'h0130, 0, 0, 0);
    repeat (5) cyc(1, 0, 1, K_NONE);
    chk("pause_hold", 16'h0130, 0, 0, 0);
    cyc(1, 0, 0, K_START); chk("resume", 16'h0130, 1, 0, 0);
    cyc(1, 0, 1, K_NONE); chk("tick_0129", 16'h0129, 1, 0, 0);
    cyc(1, 0, 0, K_STOP); chk("stop_0130", 16'h0130, 0, 0, 0);

    // Saturation at MAX_MIN:59, CE gating, CLR mid-run.
    cyc(1, 0, 0, K_STOP);
    repeat (MAX_SEC) cyc(1, 0, 0, K_INC);
    chk("set_max", 16'h9959, 0, 0, 0);
    cyc(1, 0, 0, K_INC); chk("inc_sat", 16'h9959, 0, 0, 0);
    cyc(1, 0, 0, K_START);
    cyc(0, 0, 1, K_NONE); chk("ce_low_tick", 16'h9959, 1, 0, 0);
    cyc(0, 0, 0, K_STOP); chk("ce_low_stop", 16'h9959, 1, 0, 0);
    cyc(1, 0, 1, K_NONE); chk("tick_9958", 16'h9958, 1, 0, 0);
    cyc(0, 1, 0, K_NONE); chk("clr_run", 16'h0000, 0, 0, 0);

    // Random traffic; the negedge compare checks every cycle.
    for (int n = 0; n < 4000; n++) begin
      bit [3:0] k;
      k[3] = ($urandom_range(0, 99) < 4);
      k[2] = ($urandom_range(0, 99) < 8);
      k[1] = ($urandom_range(0, 99) < 12);
      k[0] = ($urandom_range(0, 99) < 8);
      cyc(($urandom_range(0, 99) < 85), ($urandom_range(0, 199) == 0),
          ($urandom_range(0, 99) < 35), k);
    end

    cyc(1, 0, 0, K_NONE);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
Control FSM for the countdown timer. It holds the MM:SS time value as four BCD digits and applies preset adjustment from the debounced keys. It starts, pauses and stops the countdown, decrements once per 1 s tick, and raises an alarm at 00:00. Its Q output feeds the 7-segment driver data bus directly, replacing the free-running seconds counter and the binary-to-BCD divide logic.

Parameters:
MAX_MIN, 99, maximum minutes value (1..99); INC saturates at MAX_MIN:59
ALARM_TICKS, 10, number of TICK strobes spent in DONE before auto-return to IDLE (1..255)

Ports:
CLK  in  1  system clock
CLR  in  1  synchronous reset, active-high
CE  in  1  clock enable; all inputs are sampled and state updates occur only on cycles with CE=1
TICK  in  1  1 s strobe from the prescaler, one cycle wide, meaningful only when CE=1
KEY_START  in  1  debounced start/pause pulse, one cycle wide
KEY_STOP  in  1  debounced stop/reset pulse
KEY_INC  in  1  debounced +1 s pulse; auto-repeat comes from the debouncer
KEY_DEC  in  1  debounced -1 s pulse
Q  out  16  BCD {M1,M0,S1,S0}, each nibble 0..9; S1 is 0..5
RUN  out  1  high while in RUN
ALARM  out  1  high while in DONE
BLANK  out  1  display blank request; toggles each TICK in DONE, 0 otherwise

Behaviour:
- Reset (CLR=1 at a CLK edge, regardless of CE): state=IDLE, Q=0000, preset=0000, RUN=0, ALARM=0, BLANK=0, alarm counter=0. Reset mid-countdown discards the current value.
- All outputs are registered. A response appears on the first CLK edge at which the strobe is sampled with CE=1, so latency is 1 cycle. Strobes with CE=0 are ignored; they are not queued.
- Key priority within a cycle: STOP > START > INC > DEC. Only the highest-priority asserted key acts. TICK is processed only if no key acts, except in DONE, where TICK and keys are handled as listed below.
- BCD decrement: S0-1; on S0=0, set S0=9 and S1-1; on S1=0 and S0=0, set S1=5, S0=9 and minutes-1 with the same borrow from M0 to M1. Never wraps below 0000.
- BCD increment: mirror of decrement with carries at S0=9, S1=5 and M0=9. Saturates at MAX_MIN:59.
- States:
  - IDLE:
    - INC: +1 s, saturating at MAX_MIN:59.
    - DEC: -1 s, saturating at 0000.
    - START with Q!=0: preset<=Q, go to RUN.
    - START with Q=0: ignored.
    - STOP: Q<=0000.
    - TICK: ignored.
  - RUN:
    - TICK: decrement. If the pre-decrement value is 00:01, Q becomes 0000, go to DONE, ALARM=1 on the same edge, alarm counter=0.
    - START: go to PAUSE; Q is held; a coincident TICK is dropped.
    - STOP: Q<=preset, go to IDLE.
    - INC/DEC: ignored.
  - PAUSE:
    - START: go to RUN; the next TICK decrements.
    - STOP: Q<=preset, go to IDLE.
    - TICK/INC/DEC: ignored.
  - DONE:
    - Q is held at 0000.
    - Each TICK: BLANK toggles and the alarm counter increments.
    - When the counter reaches ALARM_TICKS: go to IDLE, Q<=preset, ALARM=0, BLANK=0.
    - Any key (START/STOP/INC/DEC): immediate go to IDLE, Q<=preset, ALARM=0, BLANK=0; the key's own function is not applied.
- Q digits are always valid BCD. Illegal states (unused FSM encoding) recover to IDLE on the next CE cycle.

Test Plan:
- Reset, then 3×INC, START, 3×TICK -> Q: 0000→0001→0002→0003; RUN=1; Q 0002, 0001, then 0000 with ALARM=1, RUN=0.
- From IDLE Q=0000, DEC then START -> Q stays 0000; state stays IDLE; RUN=0.
- Q=0100 in RUN, one TICK -> Q=0059 (borrow across S1 and M0); second TICK -> Q=0058.
- Q=0130 in RUN, START+TICK in the same cycle -> PAUSE, Q=0130. 5 TICKs -> no change. START, TICK -> Q=0129. STOP -> Q=0130 (preset), IDLE.
- In DONE with ALARM_TICKS=10 -> BLANK toggles on each of the first 9 TICKs. On the 10th TICK -> IDLE, Q=preset, ALARM=0, BLANK=0. Repeat, pressing INC after 2 TICKs -> IDLE immediately with Q=preset, not preset+1.
- Q=MAX_MIN:59 (9959), INC -> Q unchanged. TICK with CE=0 in RUN -> no decrement. CLR asserted in RUN -> Q=0000, IDLE next cycle.
